// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding, access-size codes and default timeout for the data-memory bridge
package dmem_pkg;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam int DEFAULT_TIMEOUT = 255;
    function automatic logic f3_legal(input logic [2:0] f3);
        return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction
endpackage

// File: rtl/dmem_bridge_if.sv
// dmem_bridge_if: word-addressed memory bus between the bridge (master) and the memory (slave)
interface dmem_bridge_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    modport master (output req, we, addr, wdata, be, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, be, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_bridge_load_ext.sv
// load_ext: selects the addressed byte/halfword of a bus word and sign- or zero-extends it
module load_ext
    import dmem_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] ext
);
    logic [7:0]  b;
    logic [15:0] h;
    assign b = data[{off, 3'b000} +: 8];
    assign h = off[1] ? data[31:16] : data[15:0];
    assign ext = funct3 == F3_B  ? {{24{b[7]}}, b} :
                 funct3 == F3_BU ? {24'b0, b} :
                 funct3 == F3_H  ? {{16{h[15]}}, h} :
                 funct3 == F3_HU ? {16'b0, h} : data;
endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge: turns core load/store requests into lane-positioned word bus accesses,
// stalling the core until the access completes, errors out or times out.
module dmem_bridge
    import dmem_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         mem_addr,
    input  logic [31:0]         mem_wdata,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [2:0]          mem_funct3,
    output logic [31:0]         mem_rdata,
    output logic                stall,
    output logic                err,
    dmem_bridge_if.master       bus
);
    state_t      state_q, state_d;
    logic        req_q, req_d, we_q, we_d, terr_q, terr_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]  be_q, be_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  f3_q, f3_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [8:0]  cnt_inc;
    logic        expired, misaligned, bad, go;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata, ext;

    assign misaligned = (mem_funct3[1:0] == 2'b01 && mem_addr[0]) ||
                        (mem_funct3[1:0] == 2'b10 && mem_addr[1:0] != 2'b00);
    assign bad = !f3_legal(mem_funct3) || misaligned || (mem_read && mem_write);
    assign go = (mem_read ^ mem_write) && !bad;
    assign lane_be = mem_funct3[1:0] == 2'b00 ? 4'b0001 << mem_addr[1:0] :
                     mem_funct3[1:0] == 2'b01 ? (mem_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign lane_wdata = mem_funct3[1:0] == 2'b00 ? {4{mem_wdata[7:0]}} :
                        mem_funct3[1:0] == 2'b01 ? {2{mem_wdata[15:0]}} : mem_wdata;
    assign cnt_inc = {1'b0, cnt_q} + 9'd1;
    assign expired = cnt_inc >= 9'(TIMEOUT);

    load_ext u_load_ext (.data(rdata_q), .off(off_q), .funct3(f3_q), .ext(ext));

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        off_d   = off_q;
        f3_d    = f3_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        terr_d  = terr_q;
        case (state_q)
            S_IDLE: if (go) begin
                state_d = S_REQ;
                req_d   = 1'b1;
                we_d    = mem_write;
                addr_d  = {mem_addr[31:2], 2'b00};
                wdata_d = lane_wdata;
                be_d    = lane_be;
                off_d   = mem_addr[1:0];
                f3_d    = mem_funct3;
                cnt_d   = '0;
                terr_d  = 1'b0;
            end
            S_REQ: begin
                cnt_d = cnt_inc[7:0];
                if (bus.gnt) begin
                    req_d   = 1'b0;
                    state_d = (we_q || bus.rvalid) ? S_DONE : S_WAIT;
                    rdata_d = (!we_q && bus.rvalid) ? bus.rdata : rdata_q;
                end else if (expired) begin
                    req_d   = 1'b0;
                    state_d = S_DONE;
                    terr_d  = 1'b1;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_inc[7:0];
                if (bus.rvalid) begin
                    state_d = S_DONE;
                    rdata_d = bus.rdata;
                end else if (expired) begin
                    state_d = S_DONE;
                    terr_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                terr_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            off_q   <= '0;
            f3_q    <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            off_q   <= off_d;
            f3_q    <= f3_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
        end
    end

    assign bus.req   = req_q;
    assign bus.we    = we_q;
    assign bus.addr  = addr_q;
    assign bus.wdata = wdata_q;
    assign bus.be    = be_q;
    assign stall     = state_q == S_REQ || state_q == S_WAIT || (state_q == S_IDLE && go);
    // Rejected accesses flag err in the request cycle; timeouts flag it in DONE.
    assign err = rst && ((state_q == S_IDLE && (mem_read || mem_write) && bad) ||
                         (state_q == S_DONE && terr_q));
    assign mem_rdata = (state_q == S_DONE && !terr_q && !we_q) ? ext : '0;
endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed checks of dmem_bridge stores, loads, rejects, timeout and reset abort
module tb_dmem_bridge;
    import dmem_pkg::*;
    logic        clk = 0, rst = 0;
    logic [31:0] mem_addr = 0, mem_wdata = 0;
    logic        mem_read = 0, mem_write = 0, rd_to = 0;
    logic [2:0]  mem_funct3 = 0;
    logic [31:0] mem_rdata, mem_rdata_to;
    logic        stall, err, stall_to, err_to;
    int          checks = 0, failures = 0;

    dmem_bridge_if bus_i();
    dmem_bridge_if bus_t();

    dmem_bridge dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_funct3(mem_funct3),
        .mem_rdata(mem_rdata), .stall(stall), .err(err), .bus(bus_i.master)
    );

    dmem_bridge #(.TIMEOUT(4)) dut_to (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(rd_to), .mem_write(1'b0), .mem_funct3(mem_funct3),
        .mem_rdata(mem_rdata_to), .stall(stall_to), .err(err_to), .bus(bus_t.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_store(input string tag, input logic [31:0] a, input logic [2:0] f3,
                            input logic [31:0] wd, input int gnt_delay,
                            input logic [3:0] exp_be, input logic [31:0] exp_wd);
        @(negedge clk);
        mem_write = 1; mem_addr = a; mem_funct3 = f3; mem_wdata = wd;
        #1 chk({tag, " idle stall"}, stall, 1);
        chk({tag, " idle req"}, bus_i.req, 0);
        for (int i = 0; i <= gnt_delay; i++) begin
            @(negedge clk);
            #1 chk({tag, " req"}, bus_i.req, 1);
            chk({tag, " be"}, bus_i.be, exp_be);
            chk({tag, " addr"}, bus_i.addr, {a[31:2], 2'b00});
            chk({tag, " wdata"}, bus_i.wdata, exp_wd);
            chk({tag, " we"}, bus_i.we, 1);
            chk({tag, " stall"}, stall, 1);
        end
        bus_i.gnt = 1;
        @(negedge clk);
        bus_i.gnt = 0; mem_write = 0;
        #1 chk({tag, " done stall"}, stall, 0);
        chk({tag, " done err"}, err, 0);
        chk({tag, " done req"}, bus_i.req, 0);
    endtask

    task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] f3,
                           input logic [31:0] rd, input int waits, input logic [31:0] exp);
        @(negedge clk);
        mem_read = 1; mem_addr = a; mem_funct3 = f3;
        #1 chk({tag, " idle stall"}, stall, 1);
        @(negedge clk);
        #1 chk({tag, " req"}, bus_i.req, 1);
        chk({tag, " addr"}, bus_i.addr, {a[31:2], 2'b00});
        chk({tag, " we"}, bus_i.we, 0);
        bus_i.gnt = 1;
        if (waits == 0) begin
            bus_i.rvalid = 1; bus_i.rdata = rd;
        end
        @(negedge clk);
        bus_i.gnt = 0;
        if (waits > 0) begin
            #1 chk({tag, " wait req"}, bus_i.req, 0);
            chk({tag, " wait stall"}, stall, 1);
            for (int i = 1; i < waits; i++) @(negedge clk);
            bus_i.rvalid = 1; bus_i.rdata = rd;
            @(negedge clk);
        end
        bus_i.rvalid = 0; bus_i.rdata = 32'hFFFF_FFFF; mem_read = 0;
        #1 chk({tag, " rdata"}, mem_rdata, exp);
        chk({tag, " done stall"}, stall, 0);
        chk({tag, " done err"}, err, 0);
    endtask

    task automatic do_reject(input string tag, input logic rd, input logic wr,
                             input logic [31:0] a, input logic [2:0] f3);
        @(negedge clk);
        mem_read = rd; mem_write = wr; mem_addr = a; mem_funct3 = f3;
        #1 chk({tag, " err"}, err, 1);
        chk({tag, " stall"}, stall, 0);
        chk({tag, " rdata"}, mem_rdata, 0);
        chk({tag, " req"}, bus_i.req, 0);
        @(negedge clk);
        mem_read = 0; mem_write = 0;
        #1 chk({tag, " err pulse"}, err, 0);
        chk({tag, " no req"}, bus_i.req, 0);
    endtask

    initial begin
        bus_i.gnt = 0; bus_i.rvalid = 0; bus_i.rdata = 0;
        bus_t.gnt = 0; bus_t.rvalid = 0; bus_t.rdata = 0;
        repeat (2) @(negedge clk);
        #1 chk("rst stall", stall, 0);
        chk("rst err", err, 0);
        chk("rst req", bus_i.req, 0);
        chk("rst we", bus_i.we, 0);
        chk("rst be", bus_i.be, 0);
        chk("rst addr", bus_i.addr, 0);
        chk("rst wdata", bus_i.wdata, 0);
        chk("rst rdata", mem_rdata, 0);
        @(negedge clk);
        rst = 1;

        do_store("sw", 32'h100, F3_W, 32'hDEAD_BEEF, 0, 4'b1111, 32'hDEAD_BEEF);
        do_store("sh", 32'h302, F3_H, 32'h0000_ABCD, 2, 4'b1100, 32'hABCD_ABCD);
        do_store("sb", 32'h101, F3_B, 32'h1234_565A, 1, 4'b0010, 32'h5A5A_5A5A);

        do_load("lb", 32'h203, F3_B, 32'h80FF_1234, 3, 32'hFFFF_FF80);
        do_load("lbu", 32'h203, F3_BU, 32'h80FF_1234, 3, 32'h0000_0080);
        do_load("lh", 32'h202, F3_H, 32'h80FF_1234, 0, 32'hFFFF_80FF);
        do_load("lhu", 32'h200, F3_HU, 32'h80FF_1234, 1, 32'h0000_1234);
        do_load("lw", 32'h204, F3_W, 32'h80FF_1234, 0, 32'h80FF_1234);
        do_load("lb0", 32'h200, F3_B, 32'h80FF_1234, 0, 32'h0000_0034);

        do_reject("lw_mis", 1, 0, 32'h401, F3_W);
        do_reject("sh_mis", 0, 1, 32'h303, F3_H);
        do_reject("f3_ill", 1, 0, 32'h400, 3'b011);
        do_reject("rd_wr", 1, 1, 32'h400, F3_W);

        @(negedge clk);
        rd_to = 1; mem_addr = 32'h500; mem_funct3 = F3_W;
        #1 chk("to idle stall", stall_to, 1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            #1 chk($sformatf("to req%0d", i), bus_t.req, 1);
            chk($sformatf("to stall%0d", i), stall_to, 1);
            chk($sformatf("to err%0d", i), err_to, 0);
        end
        @(negedge clk);
        rd_to = 0;
        #1 chk("to done err", err_to, 1);
        chk("to done rdata", mem_rdata_to, 0);
        chk("to done stall", stall_to, 0);
        chk("to done req", bus_t.req, 0);
        @(negedge clk);
        #1 chk("to err pulse", err_to, 0);

        @(negedge clk);
        mem_read = 1; mem_addr = 32'h604; mem_funct3 = F3_W;
        @(negedge clk);
        bus_i.gnt = 1;
        @(negedge clk);
        bus_i.gnt = 0; mem_read = 0;
        #1 chk("rw wait stall", stall, 1);
        #2 rst = 0;
        #1 chk("rw rst req", bus_i.req, 0);
        chk("rw rst stall", stall, 0);
        chk("rw rst addr", bus_i.addr, 0);
        chk("rw rst err", err, 0);
        @(negedge clk);
        rst = 1;
        bus_i.rvalid = 1; bus_i.rdata = 32'h5555_AAAA;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus_i.rvalid = 0;
            #1 chk("rw after err", err, 0);
            chk("rw after rdata", mem_rdata, 0);
            chk("rw after stall", stall, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
